pipeline_stall_ctrl: RTL and testbench

// - Central stall/flush controller for the pipelined RISC core; generalised successor to the single-cycle load-use stall unit.
// - Drives per-stage write enables and bubble (NOP-insert) strobes for the PC and all pipeline registers.
// - Adds multi-cycle load stalls, memory-busy freeze, branch flush and optional stall statistics.
// - Sits beside the hazard detection unit; its outputs go directly to the PC and the pipeline register enables/clears.

---
 rtl/pipeline_stall_ctrl.sv | 86 ++++++++
 tb/tb_pipeline_stall_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: per-stage enable/bubble control for load, memory-busy and flush stalls.
// Define PIPE_STALL_PERF_EN to build the load-stall and flush performance counters.
module pipeline_stall_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int HOLD_STAGES = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_STALL  = 1,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_for_load,
  input  logic                  mem_busy,
  input  logic                  flush_req,
  output logic [NUM_STAGES-1:0] stage_enable,
  output logic [NUM_STAGES-1:0] stage_bubble,
  output logic                  stall_active,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
);
  localparam logic [NUM_STAGES-1:0] TOP_BIT   = NUM_STAGES'(1 << (NUM_STAGES - 1));
  localparam logic [NUM_STAGES-1:0] FLUSH_BUB = NUM_STAGES'((1 << (FLUSH_DEPTH + 1)) - 2);
  localparam logic [NUM_STAGES-1:0] HOLD_MASK = NUM_STAGES'((1 << HOLD_STAGES) - 1);
  localparam logic [NUM_STAGES-1:0] HOLD_BUB  = NUM_STAGES'(1 << HOLD_STAGES);
  typedef enum logic {IDLE, LSTALL} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_cyc;
  // mem_busy freezes state and cnt so a pending load stall resumes afterwards
  always_comb begin
    stage_enable = '1;
    stage_bubble = '0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_cyc     = ~mem_busy & ~flush_req & ((state_q == LSTALL) | stall_for_load);
    if (mem_busy) begin
      stage_enable = TOP_BIT;
      stage_bubble = TOP_BIT;
    end else if (flush_req) begin
      stage_bubble = FLUSH_BUB;
      state_d      = IDLE;
      cnt_d        = '0;
    end else if (load_cyc) begin
      stage_enable = ~HOLD_MASK;
      stage_bubble = HOLD_BUB;
      if (state_q == LSTALL) begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? IDLE : LSTALL;
      end else if (LOAD_STALL > 1) begin
        state_d = LSTALL;
        cnt_d   = CNT_W'(LOAD_STALL - 1);
      end
    end
  end
  assign stall_active = ~&stage_enable;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;
  always_comb begin
    perf_stall_d = perf_stall_q + 32'(load_cyc);
    perf_flush_d = perf_flush_q + 32'(~mem_busy & flush_req);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: two controllers (LOAD_STALL=1 and 3) against a remaining-cycles reference model.
module tb_pipeline_stall_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_for_load = 1'b0, mem_busy = 1'b0, flush_req = 1'b0;
  logic [4:0]  en [2];
  logic [4:0]  bub [2];
  logic        sa [2];
  logic [31:0] ps [2];
  logic [31:0] pf [2];
  int          checks = 0, failures = 0;
  int          rem [2] = '{0, 0};
  int          nst [2] = '{0, 0};
  int          nfl [2] = '{0, 0};
  int          ls  [2] = '{1, 3};

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.LOAD_STALL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .stall_for_load(stall_for_load), .mem_busy(mem_busy),
    .flush_req(flush_req), .stage_enable(en[0]), .stage_bubble(bub[0]),
    .stall_active(sa[0]), .perf_stall_cnt(ps[0]), .perf_flush_cnt(pf[0]));
  pipeline_stall_ctrl #(.LOAD_STALL(3)) u3 (
    .clk(clk), .rst_n(rst_n), .stall_for_load(stall_for_load), .mem_busy(mem_busy),
    .flush_req(flush_req), .stage_enable(en[1]), .stage_bubble(bub[1]),
    .stall_active(sa[1]), .perf_stall_cnt(ps[1]), .perf_flush_cnt(pf[1]));

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d got=%0h exp=%0h", tag, i, got, exp);
    end
  endtask

  task automatic chk_outputs(input int i, input logic [4:0] e_en, input logic [4:0] e_bub);
    logic [31:0] e_ps, e_pf;
`ifdef PIPE_STALL_PERF_EN
    e_ps = 32'(nst[i]);
    e_pf = 32'(nfl[i]);
`else
    e_ps = 32'd0;
    e_pf = 32'd0;
`endif
    chk("enable", i, 32'(en[i]), 32'(e_en));
    chk("bubble", i, 32'(bub[i]), 32'(e_bub));
    chk("stall_active", i, 32'(sa[i]), 32'(e_en != 5'b11111));
    chk("perf_stall", i, ps[i], e_ps);
    chk("perf_flush", i, pf[i], e_pf);
  endtask

  // one clock cycle: apply inputs, check combinational outputs, then advance the model
  task automatic step(input logic b, input logic f, input logic s);
    mem_busy = b;
    flush_req = f;
    stall_for_load = s;
    #4;
    for (int i = 0; i < 2; i++) begin
      if (b)                  chk_outputs(i, 5'b10000, 5'b10000);
      else if (f)             chk_outputs(i, 5'b11111, 5'b00110);
      else if (rem[i] > 0 || s) chk_outputs(i, 5'b11000, 5'b01000);
      else                    chk_outputs(i, 5'b11111, 5'b00000);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (b) begin
      end else if (f) begin
        nfl[i]++;
        rem[i] = 0;
      end else if (rem[i] > 0) begin
        nst[i]++;
        rem[i]--;
      end else if (s) begin
        nst[i]++;
        rem[i] = ls[i] - 1;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0;
      nst[i] = 0;
      nfl[i] = 0;
    end
  endtask

  initial begin
    #2;
    for (int i = 0; i < 2; i++) chk_outputs(i, 5'b11111, 5'b00000);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    mem_busy = 1'b0;
    flush_req = 1'b0;
    stall_for_load = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) chk_outputs(i, 5'b11111, 5'b00000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
    end
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
